// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the PC, reads a 1-cycle-latency ROM and buffers words in a prefetch FIFO for decode.
// Define FETCH_STATS_EN to add the saturating stall_cnt output (decode ready but nothing valid).
module fetch_queue #(
    parameter int INSTR_W = 4,
    parameter int OPER_W  = 4,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [INSTR_W+OPER_W-1:0]   mem_data,
    input  logic                        branch_en,
    input  logic [ADDR_W-1:0]           branch_target,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTR_W-1:0]          instr,
    output logic [OPER_W-1:0]           operand,
    output logic [ADDR_W-1:0]           out_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int WORD_W = INSTR_W + OPER_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflightAddr;

    logic [WORD_W-1:0] dataQ [DEPTH];
    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;

    // Slots are reserved at issue time by counting the in-flight word, so a push never finds the FIFO full.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign mem_req   = !reset && !branch_en && (occupancy < (CNT_W+1)'(DEPTH));
    assign mem_addr  = pc;

    // A word arriving in a branch cycle belongs to the old path and is dropped with the flush.
    assign push      = inflight && !branch_en;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign instr   = out_valid ? dataQ[rdPtr][WORD_W-1:OPER_W] : '0;
    assign operand = out_valid ? dataQ[rdPtr][OPER_W-1:0]      : '0;
    assign out_pc  = out_valid ? addrQ[rdPtr]                  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= '0;
            inflight     <= 1'b0;
            inflightAddr <= '0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                inflightAddr <= pc;
                pc           <= pc + ADDR_W'(1);
            end else if (branch_en) begin
                pc <= branch_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (branch_en) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so no stale entry can ever reach the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dataQ[i] <= '0;
                addrQ[i] <= '0;
            end
        end else if (push) begin
            dataQ[wrPtr] <= mem_data;
            addrQ[wrPtr] <= inflightAddr;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_ready && !out_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
